// File: rtl/n64_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | n64_pkg : shared N64 line timing and reader FSM state encoding           |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
package n64_pkg;

  localparam int c_CLKS_PER_US  = 100;
  // Writer bit cell: START low, DATA phase, STOP high; the reader samples mid-DATA.
  localparam int c_WR_START_CNT = 1 * c_CLKS_PER_US;
  localparam int c_WR_DATA_CNT  = 2 * c_CLKS_PER_US;
  localparam int c_WR_STOP_CNT  = 1 * c_CLKS_PER_US;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_EDGE   = 3'd1,
    WAIT_SAMPLE = 3'd2,
    WAIT_STOP   = 3'd3,
    DONE        = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/n64_line_sync.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | n64_line_sync : 2-flop synchronizer with falling-edge detect            |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
module n64_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic data_in,
  output logic level,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Flops reset high to match the idle level of the open-drain line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= data_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign fall  = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/n64_read_response.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | n64_read_response : captures the controller status reply by pulse timing|
// | Optional stop-bit check: define N64_RESP_STOP_CHECK_EN                   |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
module n64_read_response
  import n64_pkg::*;
#(
  parameter int SAMPLE_PT     = c_WR_START_CNT + c_WR_DATA_CNT / 2,
  parameter int FIRST_TIMEOUT = 10 * c_CLKS_PER_US,
  parameter int BIT_TIMEOUT   = 3 * (c_WR_START_CNT + c_WR_DATA_CNT + c_WR_STOP_CNT) / 2,
  parameter int NUM_BITS      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  input  logic        start,
  output logic [31:0] response,
  output logic        valid,
  output logic        busy,
  output logic        timeout_err
);

  logic        w_level;
  logic        w_fall;
  logic [9:0]  w_edge_limit;

  state_t      r_state;
  logic [9:0]  r_cnt;
  logic [5:0]  r_bit_idx;
  logic [31:0] r_shift;

  n64_line_sync u_line_sync (
    .clk     (clk),
    .reset   (reset),
    .data_in (data_in),
    .level   (w_level),
    .fall    (w_fall)
  );

  // The controller gets a longer window to begin answering than between bits.
  assign w_edge_limit = (r_bit_idx == 6'd0) ? 10'(FIRST_TIMEOUT - 1) : 10'(BIT_TIMEOUT - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 10'd0;
      r_bit_idx   <= 6'd0;
      r_shift     <= 32'd0;
      response    <= 32'd0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      r_cnt       <= r_cnt + 10'd1;
      case (r_state)
        IDLE: begin
          r_cnt <= 10'd0;
          if (start) begin
            r_bit_idx <= 6'd0;
            r_shift   <= 32'd0;
            busy      <= 1'b1;
            r_state   <= WAIT_EDGE;
          end
        end
        WAIT_EDGE, WAIT_STOP: begin
          if (w_fall) begin
            r_cnt   <= 10'd0;
            r_state <= (r_state == WAIT_STOP) ? DONE : WAIT_SAMPLE;
          end else if (r_cnt == w_edge_limit) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_state     <= IDLE;
          end
        end
        WAIT_SAMPLE: begin
          // Falls before the sample point are glitches and deliberately ignored.
          if (r_cnt == 10'(SAMPLE_PT - 1)) begin
            r_shift   <= {r_shift[30:0], w_level};
            r_bit_idx <= r_bit_idx + 6'd1;
            r_cnt     <= 10'd0;
            if (r_bit_idx == 6'(NUM_BITS - 1)) begin
`ifdef N64_RESP_STOP_CHECK_EN
              r_state <= WAIT_STOP;
`else
              r_state <= DONE;
`endif
            end else begin
              r_state <= WAIT_EDGE;
            end
          end
        end
        DONE: begin
          response <= r_shift;
          valid    <= 1'b1;
          busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_n64_read_response.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_n64_read_response : randomized self-checking bench for the reader     |
// | Rev 1.0 : initial release                                               |
// +-------------------------------------------------------------------------+
module tb_n64_read_response;

  localparam int SAMPLE_PT     = 200;
  localparam int FIRST_TIMEOUT = 1000;
  localparam int BIT_TIMEOUT   = 600;
`ifdef N64_RESP_STOP_CHECK_EN
  localparam bit STOP_CHECK = 1'b1;
`else
  localparam bit STOP_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_in = 1'b1;
  logic        start = 1'b0;
  logic [31:0] response;
  logic        valid;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid, n_to, busy_gaps, total_both;
  int valid_cyc, to_cyc, start_cyc, last_fall_cyc;
  bit track = 1'b0;
  logic busy_s1;
  logic [31:0] model_resp = 32'd0;

  n64_read_response dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .start       (start),
    .response    (response),
    .valid       (valid),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin n_valid++; valid_cyc = cyc; end
    if (timeout_err) begin n_to++; to_cyc = cyc; end
    if (valid && timeout_err) total_both++;
    if (track && !busy && !valid && !timeout_err) busy_gaps++;
    if (valid || timeout_err) track = 1'b0;
  end

  task automatic clear_mon;
    n_valid = 0; n_to = 0; busy_gaps = 0;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1; start_cyc = cyc + 1;
    @(negedge clk); start = 1'b0; busy_s1 = busy; track = 1'b1;
  endtask

  // 1 = 1 us low / 3 us high, 0 = 3 us low / 1 us high
  task automatic send_bit(input bit b);
    @(negedge clk); data_in = 1'b0; last_fall_cyc = cyc + 1;
    repeat (b ? 100 : 300) @(negedge clk);
    data_in = 1'b1;
    repeat (b ? 299 : 99) @(negedge clk);
  endtask

  task automatic send_reply(input logic [31:0] w, input int nbits, input bit stop);
    pulse_start();
    repeat ($urandom_range(400, 20)) @(negedge clk);
    for (int i = 0; i < nbits; i++) send_bit(w[31-i]);
    if (stop) begin
      @(negedge clk); data_in = 1'b0;
      repeat (100) @(negedge clk);
      data_in = 1'b1;
      repeat (200) @(negedge clk);
    end
  endtask

  task automatic wait_outcome(input int limit);
    for (int k = 0; k < limit && (n_valid + n_to) == 0; k++) @(negedge clk);
    track = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (response !== 32'h0) begin errors++; $display("FAIL reset_response: got %h expected 0", response); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
    start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_with_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_msb_only;
    logic [31:0] w;
    bit exp_ok;
    w = 32'h8000_0000;
    exp_ok = !STOP_CHECK;
    clear_mon();
    send_reply(w, 32, 1'b0);
    wait_outcome(2000);
    if (exp_ok) model_resp = w;
    checks++; if (n_valid !== int'(exp_ok)) begin errors++; $display("FAIL msb_valid_count: got %0d expected %0d", n_valid, int'(exp_ok)); end
    checks++; if (n_to !== int'(!exp_ok)) begin errors++; $display("FAIL msb_timeout_count: got %0d expected %0d", n_to, int'(!exp_ok)); end
    checks++; if (response !== model_resp) begin errors++; $display("FAIL msb_response: got %h expected %h", response, model_resp); end
    if (n_valid == 1) begin
      checks++;
      if (valid_cyc - last_fall_cyc < SAMPLE_PT || valid_cyc - last_fall_cyc > SAMPLE_PT + 5) begin
        errors++; $display("FAIL msb_latency: got %0d expected %0d..%0d", valid_cyc - last_fall_cyc, SAMPLE_PT, SAMPLE_PT + 5);
      end
    end
  endtask

  task automatic test_stop_reply;
    logic [31:0] w;
    w = 32'h1234_ABCD;
    clear_mon();
    send_reply(w, 32, 1'b1);
    wait_outcome(2000);
    model_resp = w;
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL stop_valid_count: got %0d expected 1", n_valid); end
    checks++; if (n_to !== 0) begin errors++; $display("FAIL stop_timeout_count: got %0d expected 0", n_to); end
    checks++; if (response !== model_resp) begin errors++; $display("FAIL stop_response: got %h expected %h", response, model_resp); end
    checks++; if (busy_s1 !== 1'b1) begin errors++; $display("FAIL busy_after_start: got %b expected 1", busy_s1); end
    checks++; if (busy_gaps !== 0) begin errors++; $display("FAIL busy_held: got %0d low cycles expected 0", busy_gaps); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_valid: got %b expected 0", busy); end
  endtask

  task automatic test_no_answer;
    clear_mon();
    pulse_start();
    wait_outcome(FIRST_TIMEOUT + 200);
    checks++; if (n_to !== 1) begin errors++; $display("FAIL noans_timeout_count: got %0d expected 1", n_to); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL noans_valid_count: got %0d expected 0", n_valid); end
    checks++;
    if (to_cyc - start_cyc < FIRST_TIMEOUT - 3 || to_cyc - start_cyc > FIRST_TIMEOUT + 3) begin
      errors++; $display("FAIL noans_timeout_delay: got %0d expected %0d+-3", to_cyc - start_cyc, FIRST_TIMEOUT);
    end
    checks++; if (response !== model_resp) begin errors++; $display("FAIL noans_response: got %h expected %h", response, model_resp); end
  endtask

  task automatic test_stall;
    clear_mon();
    send_reply($urandom, 10, 1'b0);
    wait_outcome(3000);
    checks++; if (n_to !== 1) begin errors++; $display("FAIL stall_timeout_count: got %0d expected 1", n_to); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL stall_valid_count: got %0d expected 0", n_valid); end
    checks++;
    if (to_cyc - last_fall_cyc < BIT_TIMEOUT || to_cyc - last_fall_cyc > SAMPLE_PT + BIT_TIMEOUT + 5) begin
      errors++; $display("FAIL stall_timeout_delay: got %0d expected %0d..%0d", to_cyc - last_fall_cyc, BIT_TIMEOUT, SAMPLE_PT + BIT_TIMEOUT + 5);
    end
    checks++; if (response !== model_resp) begin errors++; $display("FAIL stall_response: got %h expected %h", response, model_resp); end
  endtask

  task automatic test_line_low;
    clear_mon();
    pulse_start();
    repeat (50) @(negedge clk);
    data_in = 1'b0;
    wait_outcome(3000);
    data_in = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (n_to !== 1) begin errors++; $display("FAIL low_timeout_count: got %0d expected 1", n_to); end
    checks++; if (n_valid !== 0) begin errors++; $display("FAIL low_valid_count: got %0d expected 0", n_valid); end
    checks++; if (response !== model_resp) begin errors++; $display("FAIL low_response: got %h expected %h", response, model_resp); end
  endtask

  task automatic test_reset_mid_reply;
    logic [31:0] w;
    w = $urandom;
    clear_mon();
    pulse_start();
    repeat ($urandom_range(200, 20)) @(negedge clk);
    for (int i = 0; i < 15; i++) send_bit(w[31-i]);
    @(negedge clk); data_in = 1'b0;
    repeat (50) @(negedge clk);
    #2 reset = 1'b1; track = 1'b0;
    #1;
    model_resp = 32'd0;
    checks++;
    if ({response, valid, busy, timeout_err} !== 35'd0) begin
      errors++; $display("FAIL midreset_outputs: got resp=%h v=%b b=%b t=%b expected all 0", response, valid, busy, timeout_err);
    end
    data_in = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (1200) @(negedge clk);
    checks++; if (n_valid + n_to !== 0) begin errors++; $display("FAIL midreset_no_pulse: got %0d pulses expected 0", n_valid + n_to); end
    clear_mon();
    send_reply(32'hFFFF_FFFF, 32, 1'b1);
    wait_outcome(2000);
    model_resp = 32'hFFFF_FFFF;
    checks++; if (n_valid !== 1) begin errors++; $display("FAIL after_reset_valid_count: got %0d expected 1", n_valid); end
    checks++; if (response !== model_resp) begin errors++; $display("FAIL after_reset_response: got %h expected %h", response, model_resp); end
  endtask

  task automatic test_stop_omitted;
    logic [31:0] w;
    bit exp_ok;
    w = $urandom;
    exp_ok = !STOP_CHECK;
    clear_mon();
    send_reply(w, 32, 1'b0);
    wait_outcome(2000);
    if (exp_ok) model_resp = w;
    checks++; if (n_valid !== int'(exp_ok)) begin errors++; $display("FAIL nostop_valid_count: got %0d expected %0d", n_valid, int'(exp_ok)); end
    checks++; if (n_to !== int'(!exp_ok)) begin errors++; $display("FAIL nostop_timeout_count: got %0d expected %0d", n_to, int'(!exp_ok)); end
    checks++; if (response !== model_resp) begin errors++; $display("FAIL nostop_response: got %h expected %h", response, model_resp); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_msb_only();
    test_stop_reply();
    test_no_answer();
    test_stall();
    test_line_low();
    test_reset_mid_reply();
    test_stop_omitted();
    checks++; if (total_both !== 0) begin errors++; $display("FAIL valid_and_timeout_together: got %0d cycles expected 0", total_both); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
